// File: rtl/morse_sequencer_pkg.sv
// Shared definitions for the Morse sequencer: FSM state encoding, element bit
// patterns, the ROM output bundle and the pattern builder used by the ROM.
package morse_sequencer_pkg;

  localparam int CODE_W = 20;

  localparam logic [1:0]        DOT_BITS   = 2'b10;
  localparam logic [3:0]        DASH_BITS  = 4'b1110;
  localparam logic [CODE_W-1:0] SPACE_CODE = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              s3;
    logic              s7;
    logic [CODE_W-1:0] code;
  } rom_out_t;

  // len: element count (1..5); elems: bit4 is the first element, 1 = dash.
  // Elements are shifted in at the LSB end and the result is left-aligned.
  function automatic logic [CODE_W-1:0] build_code(input logic [2:0] len,
                                                   input logic [4:0] elems);
    logic [CODE_W-1:0] acc;
    logic [4:0]        e;
    logic [2:0]        left;
    int                used;
    acc  = '0;
    e    = elems;
    left = len;
    used = 0;
    for (int i = 0; i < 5; i++) begin
      if (left != 3'd0) begin
        if (e[4]) begin
          acc  = {acc[CODE_W-5:0], DASH_BITS};
          used = used + 4;
        end else begin
          acc  = {acc[CODE_W-3:0], DOT_BITS};
          used = used + 2;
        end
        left = left - 3'd1;
      end
      e = {e[3:0], 1'b0};
    end
    return acc << (CODE_W - used);
  endfunction

endpackage

// File: rtl/morse_sequencer_rom.sv
// Character-to-pattern ROM (combinational).
// Ports:
//   ascii  in   8   character code (lower case folded to upper here)
//   entry  out  23  {valid, s3, s7, code[19:0]}; valid=0 for unsupported codes
module morse_sequencer_rom
  import morse_sequencer_pkg::*;
(
  input  logic [7:0] ascii,
  output rom_out_t   entry
);

  logic [7:0] up;
  logic [7:0] tbl;  // {len[2:0], elems[4:0]}; zero means "not in table"

  always_comb begin
    up = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A) up = ascii - 8'h20;

    tbl = 8'h00;
    case (up)
      "A": tbl = {3'd2, 5'b01000};
      "B": tbl = {3'd4, 5'b10000};
      "C": tbl = {3'd4, 5'b10100};
      "D": tbl = {3'd3, 5'b10000};
      "E": tbl = {3'd1, 5'b00000};
      "F": tbl = {3'd4, 5'b00100};
      "G": tbl = {3'd3, 5'b11000};
      "H": tbl = {3'd4, 5'b00000};
      "I": tbl = {3'd2, 5'b00000};
      "J": tbl = {3'd4, 5'b01110};
      "K": tbl = {3'd3, 5'b10100};
      "L": tbl = {3'd4, 5'b01000};
      "M": tbl = {3'd2, 5'b11000};
      "N": tbl = {3'd2, 5'b10000};
      "O": tbl = {3'd3, 5'b11100};
      "P": tbl = {3'd4, 5'b01100};
      "Q": tbl = {3'd4, 5'b11010};
      "R": tbl = {3'd3, 5'b01000};
      "S": tbl = {3'd3, 5'b00000};
      "T": tbl = {3'd1, 5'b10000};
      "U": tbl = {3'd3, 5'b00100};
      "V": tbl = {3'd4, 5'b00010};
      "W": tbl = {3'd3, 5'b01100};
      "X": tbl = {3'd4, 5'b10010};
      "Y": tbl = {3'd4, 5'b10110};
      "Z": tbl = {3'd4, 5'b11000};
      "0": tbl = {3'd5, 5'b11111};
      "1": tbl = {3'd5, 5'b01111};
      "2": tbl = {3'd5, 5'b00111};
      "3": tbl = {3'd5, 5'b00011};
      "4": tbl = {3'd5, 5'b00001};
      "5": tbl = {3'd5, 5'b00000};
      "6": tbl = {3'd5, 5'b10000};
      "7": tbl = {3'd5, 5'b11000};
      "8": tbl = {3'd5, 5'b11100};
      "9": tbl = {3'd5, 5'b11110};
      default: tbl = 8'h00;
    endcase

    entry = '0;
    if (up == 8'h20) begin
      entry.valid = 1'b1;
      entry.s7    = 1'b1;
      entry.code  = SPACE_CODE;
    end else if (tbl != 8'h00) begin
      entry.valid = 1'b1;
      entry.s3    = 1'b1;
      entry.code  = build_code(tbl[7:5], tbl[4:0]);
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// Morse sequencer: buffers ASCII characters in a small FIFO and hands one
// pattern at a time to the LED blinker with a one-cycle load strobe.
// Ports:
//   blinker_clk   in   clock, posedge
//   i_rst         in   asynchronous active-high reset
//   i_char        in   [7:0] character; i_char_valid qualifies it
//   o_char_ready  out  FIFO not full
//   i_ready       in   blinker idle
//   o_morse_code  out  [19:0] pattern, bit19 first
//   o_read        out  load strobe to the blinker
//   o_s3 / o_s7   out  letter-gap / word-gap requests for the held pattern
//   o_busy        out  FIFO non-empty or FSM not idle
//   o_err         out  one-cycle pulse when an unsupported char is dropped
//
// state | meaning
// IDLE  | nothing in flight; leave when the FIFO holds a character
// POP   | decode FIFO head, load holding regs (or flag error and drop)
// ISSUE | strobe o_read as soon as the blinker is ready
// WAIT  | blinker has the pattern; wait for it to go busy
// DRAIN | wait for the blinker to finish
module morse_sequencer
  import morse_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic              blinker_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_char,
  input  logic              i_char_valid,
  output logic              o_char_ready,
  input  logic              i_ready,
  output logic [CODE_W-1:0] o_morse_code,
  output logic              o_read,
  output logic              o_s3,
  output logic              o_s7,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic             hold_load;
  state_t           state;
  state_t           state_nxt;
  rom_out_t         rom_q;

  assign o_char_ready = (count != FULL_COUNT);
  assign push         = i_char_valid & o_char_ready;
  assign pop          = (state == ST_POP);
  assign o_busy       = (count != '0) | (state != ST_IDLE);

  morse_sequencer_rom u_rom (
    .ascii (fifo_mem[rd_ptr]),
    .entry (rom_q)
  );

  // Storage needs no reset: count gates every read.
  always_ff @(posedge blinker_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_char;
  end

  always_ff @(posedge blinker_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge blinker_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      o_morse_code <= '0;
      o_s3         <= 1'b0;
      o_s7         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hold_load) begin
        o_morse_code <= rom_q.code;
        o_s3         <= rom_q.s3;
        o_s7         <= rom_q.s7;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    o_read    = 1'b0;
    o_err     = 1'b0;
    hold_load = 1'b0;
    case (state)
      ST_IDLE: if (count != '0) state_nxt = ST_POP;
      ST_POP: begin
        if (rom_q.valid) begin
          hold_load = 1'b1;
          state_nxt = ST_ISSUE;
        end else begin
          o_err     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        o_read = i_ready;
        if (i_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (!i_ready) state_nxt = ST_DRAIN;
      ST_DRAIN: if (i_ready)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

endmodule
